// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-cache main-memory arbiter: state codes,
// default widths and the grant-counter width.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;
    localparam int CNT_W      = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GRANT_I = 3'd1;
    localparam logic [2:0] ST_GRANT_D = 3'd2;
    localparam logic [2:0] ST_DONE_I  = 3'd3;
    localparam logic [2:0] ST_DONE_D  = 3'd4;

endpackage

// File: rtl/mem_arb_grant_sel.sv
// Combinational winner pick between instruction and data cache requests.
// ARB_ROUND_ROBIN_EN selects alternating priority instead of fixed D priority.
module mem_arb_grant_sel (
    input  logic i_req,
    input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_i,
    output logic grant_d
);

`ifdef ARB_ROUND_ROBIN_EN
    // last_grant=1 means D won last time, so I takes a tie
    assign grant_d = d_req & (~i_req | ~last_grant);
`else
    assign grant_d = d_req;
`endif
    assign grant_i = i_req & ~grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I-cache and D-cache block transfers onto one main-memory port.
// Optional macro ARB_ROUND_ROBIN_EN enables alternating priority on ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MIN_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_MEM_READ,
    input  logic [ADDR_W-1:0] I_MEM_ADDR,
    output logic [DATA_W-1:0] I_MEM_READDATA,
    output logic              I_MEM_BUSYWAIT,
    input  logic              D_MEM_READ,
    input  logic              D_MEM_WRITE,
    input  logic [ADDR_W-1:0] D_MEM_ADDR,
    input  logic [DATA_W-1:0] D_MEM_WRITEDATA,
    output logic [DATA_W-1:0] D_MEM_READDATA,
    output logic              D_MEM_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    localparam logic [CNT_W-1:0] MIN_LAT_C = CNT_W'(MIN_LAT);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             i_req, d_req;
    logic             grant_i, grant_d;
    logic             done;

    assign i_req = I_MEM_READ;
    assign d_req = D_MEM_READ | D_MEM_WRITE;
    assign done  = ~MEM_BUSYWAIT & (cnt >= MIN_LAT_C);

    assign I_MEM_BUSYWAIT = i_req & (state != ST_DONE_I);
    assign D_MEM_BUSYWAIT = d_req & (state != ST_DONE_D);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            last_grant <= 1'b0;
        else if (state == ST_IDLE && (grant_i || grant_d))
            last_grant <= grant_d;
    end

    mem_arb_grant_sel u_sel (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (last_grant),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );
`else
    mem_arb_grant_sel u_sel (
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            MEM_READ       <= 1'b0;
            MEM_WRITE      <= 1'b0;
            MEM_ADDR       <= '0;
            MEM_WRITEDATA  <= '0;
            I_MEM_READDATA <= '0;
            D_MEM_READDATA <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (grant_d) begin
                        // a simultaneous read+write request performs only the write
                        state         <= ST_GRANT_D;
                        MEM_ADDR      <= D_MEM_ADDR;
                        MEM_WRITEDATA <= D_MEM_WRITEDATA;
                        MEM_WRITE     <= D_MEM_WRITE;
                        MEM_READ      <= ~D_MEM_WRITE;
                    end else if (grant_i) begin
                        state     <= ST_GRANT_I;
                        MEM_ADDR  <= I_MEM_ADDR;
                        MEM_WRITE <= 1'b0;
                        MEM_READ  <= 1'b1;
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    if (done) begin
                        if (MEM_READ) begin
                            if (state == ST_GRANT_I) I_MEM_READDATA <= MEM_READDATA;
                            else                     D_MEM_READDATA <= MEM_READDATA;
                        end
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        state     <= (state == ST_GRANT_I) ? ST_DONE_I : ST_DONE_D;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE_I, ST_DONE_D: state <= ST_IDLE;
                default:              state <= ST_IDLE;
            endcase
        end
    end

endmodule
